// File: rtl/norm_pkg.sv
// Shared widths, FSM state type and the mantissa extraction helper for the
// block-floating-point normalisation path.
package norm_pkg;

    localparam int unsigned DATA_W  = 20;
    localparam int unsigned MANT_W  = 11;
    localparam int unsigned EXP_W   = 4;
    localparam int unsigned POS_W   = 5;
    localparam int unsigned POS_MIN = 9;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } norm_state_t;

    // Arithmetic right shift by the block exponent, keeping the mantissa bits.
    function automatic logic [MANT_W-1:0] mant_of(input logic signed [DATA_W-1:0] x,
                                                  input logic [EXP_W-1:0] e);
        logic signed [DATA_W-1:0] s;
        s = x >>> e;
        return s[MANT_W-1:0];
    endfunction

endpackage

// File: rtl/blk_norm_ctrl_if.sv
// Sample-in / mantissa-out stream bundle for blk_norm_ctrl.
interface blk_norm_ctrl_if;
    import norm_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_data;
    logic [EXP_W-1:0]  out_exp;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_exp, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_exp, out_last
    );

endinterface

// File: rtl/lead_pos_det.sv
// Leading-one position of |data|, clamped so small magnitudes report POS_MIN.
module lead_pos_det
    import norm_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [POS_W-1:0]  pos_c
);

    logic [DATA_W-1:0] mag;

    // Most negative input negates to itself, which still lands on the top bit.
    always_comb begin
        mag   = data[DATA_W-1] ? (~data + DATA_W'(1)) : data;
        pos_c = POS_W'(POS_MIN);
        for (int unsigned i = POS_MIN + 1; i < DATA_W; i++) begin
            if (mag[i]) pos_c = POS_W'(i);
        end
    end

endmodule

// File: rtl/blk_norm_ctrl.sv
// Buffers a block of samples, tracks the largest magnitude position, then
// replays the block as mantissas sharing one exponent.
module blk_norm_ctrl
    import norm_pkg::*;
#(
    parameter int unsigned BLK_N = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    blk_norm_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = (BLK_N > 1) ? $clog2(BLK_N) : 1;
    localparam int unsigned LEN_W = CNT_W + 1;

    norm_state_t       state;
    logic [DATA_W-1:0] sample_buf [BLK_N];
    logic [CNT_W-1:0]  wr_cnt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [LEN_W-1:0]  blk_len;
    logic [POS_W-1:0]  max_pos;

    logic              in_ready;
    logic              out_valid;
    logic              out_last;
    logic [MANT_W-1:0] out_data;
    logic [EXP_W-1:0]  out_exp;

    logic [POS_W-1:0]  det_pos;
    logic [POS_W-1:0]  pos_max_c;
    logic [EXP_W-1:0]  new_exp_c;
    logic [DATA_W-1:0] first_c;
    logic [CNT_W-1:0]  rd_nxt_c;
    logic              accept_c;
    logic              close_c;
    logic              drain_hs_c;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_data;
    assign bus.out_exp   = out_exp;

    lead_pos_det u_det (
        .data  (bus.in_data),
        .pos_c (det_pos)
    );

    // First mantissa of a one-sample block comes straight from the input.
    always_comb begin
        accept_c   = in_ready && bus.in_valid;
        close_c    = accept_c && ((wr_cnt == CNT_W'(BLK_N - 1)) || bus.in_last);
        drain_hs_c = out_valid && bus.out_ready;
        pos_max_c  = (det_pos > max_pos) ? det_pos : max_pos;
        new_exp_c  = EXP_W'(pos_max_c - POS_W'(POS_MIN));
        first_c    = (wr_cnt == '0) ? bus.in_data : sample_buf[0];
        rd_nxt_c   = rd_cnt + CNT_W'(1);
    end

    // Outputs are registered one beat ahead so out_ready never reaches out_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            blk_len   <= '0;
            max_pos   <= POS_W'(POS_MIN);
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_exp   <= '0;
            for (int unsigned i = 0; i < BLK_N; i++) sample_buf[i] <= '0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (accept_c) begin
                        sample_buf[wr_cnt] <= bus.in_data;
                        max_pos            <= pos_max_c;
                        wr_cnt             <= wr_cnt + CNT_W'(1);
                        if (close_c) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            blk_len   <= LEN_W'(wr_cnt) + LEN_W'(1);
                            out_exp   <= new_exp_c;
                            out_valid <= 1'b1;
                            out_data  <= mant_of(first_c, new_exp_c);
                            out_last  <= (wr_cnt == '0);
                            rd_cnt    <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_hs_c) begin
                        if (out_last) begin
                            state     <= FILL;
                            in_ready  <= 1'b1;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            wr_cnt    <= '0;
                            rd_cnt    <= '0;
                            max_pos   <= POS_W'(POS_MIN);
                        end else begin
                            rd_cnt   <= rd_nxt_c;
                            out_data <= mant_of(sample_buf[rd_nxt_c], out_exp);
                            out_last <= (LEN_W'(rd_nxt_c) == blk_len - LEN_W'(1));
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_blk_norm_ctrl.sv
// Directed and randomized block stimulus checked against a magnitude-based
// reference model of the shared-exponent normalisation.
module tb_blk_norm_ctrl;
    import norm_pkg::*;

    localparam int unsigned BLK_N = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    blk_norm_ctrl_if bus ();

    blk_norm_ctrl #(.BLK_N(BLK_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int blk[$];

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // Smallest shift that brings the largest magnitude into 11-bit signed range.
    function automatic int ref_exp();
        int maxabs = 0;
        int e = 0;
        foreach (blk[i]) begin
            int a = (blk[i] < 0) ? -blk[i] : blk[i];
            if (a > maxabs) maxabs = a;
        end
        while (maxabs >= (1024 << e)) e++;
        return e;
    endfunction

    function automatic int ref_mant(input int v, input int e);
        return v >>> e;
    endfunction

    task automatic check_beat(input string tag, input int k, input int n, input int e);
        check({tag, "_valid"}, int'(bus.out_valid), 1);
        check({tag, "_data"}, int'($signed(bus.out_data)), ref_mant(blk[k], e));
        check({tag, "_exp"}, int'(bus.out_exp), e);
        check({tag, "_last"}, int'(bus.out_last), (k == n - 1) ? 1 : 0);
        check({tag, "_in_ready"}, int'(bus.in_ready), 0);
    endtask

    // Called and returns on a falling edge.
    task automatic run_block(input bit use_last, input bit rnd, input int stall_at,
                             input int stall_len, input int abort_at);
        int n = blk.size();
        int e = ref_exp();
        int w;
        int s;
        for (int i = 0; i < n; i++) begin
            if (rnd && $urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_last  = 1'($urandom_range(0, 1));
                bus.in_data  = 20'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 20'(blk[i]);
            bus.in_last  = use_last && (i == n - 1);
            w = 0;
            while (!bus.in_ready && w < 100) begin
                @(negedge clk);
                w++;
            end
            if (!bus.in_ready) begin
                check("in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("first_out_valid", int'(bus.out_valid), 1);

        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_out_valid", int'(bus.out_valid), 0);
                check("rst_out_data", int'(bus.out_data), 0);
                check("rst_out_exp", int'(bus.out_exp), 0);
                check("rst_out_last", int'(bus.out_last), 0);
                check("rst_in_ready", int'(bus.in_ready), 0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            s = (k == stall_at) ? stall_len
              : (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            for (int j = 0; j < s; j++) begin
                bus.out_ready = 1'b0;
                check_beat("stall", k, n, e);
                @(negedge clk);
            end
            bus.out_ready = 1'b1;
            check_beat("beat", k, n, e);
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        check("turn_in_ready", int'(bus.in_ready), 1);
        check("turn_out_valid", int'(bus.out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int v;
        int b;
        int mag;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #12;
        check("reset_in_ready", int'(bus.in_ready), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_out_data", int'(bus.out_data), 0);
        check("reset_out_exp", int'(bus.out_exp), 0);
        check("reset_out_last", int'(bus.out_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        check("release_in_ready", int'(bus.in_ready), 0);
        @(negedge clk);
        check("first_edge_in_ready", int'(bus.in_ready), 1);

        // Small samples, no shift.
        blk = '{100, 100, 100, 100, 100, 100, 100, 100};
        run_block(1'b0, 1'b0, -1, 0, -1);
        // Mixed magnitudes.
        blk = '{1000, 262143, -5, 0, 7, 7, 7, 7};
        run_block(1'b0, 1'b0, -1, 0, -1);
        // Most negative sample.
        blk = '{-524288, 4096};
        run_block(1'b1, 1'b0, -1, 0, -1);
        // Early close.
        blk = '{512, 1024, -2048};
        run_block(1'b1, 1'b0, -1, 0, -1);
        // Backpressure on the second output.
        blk = '{300000, -1, 2, -3, 4, -5, 6, -7};
        run_block(1'b0, 1'b0, 1, 5, -1);
        // Reset during the fourth output, then a clean block.
        blk = '{-524288, 12345, -99, 5, 6, 7, 8, 9};
        run_block(1'b0, 1'b0, -1, 0, 3);
        blk = '{100, 100, 100, 100, 100, 100, 100, 100};
        run_block(1'b0, 1'b0, -1, 0, -1);
        // Single-sample block.
        blk = '{-77};
        run_block(1'b1, 1'b0, -1, 0, -1);

        for (int t = 0; t < 40; t++) begin
            blk.delete();
            n = int'($urandom_range(1, BLK_N));
            for (int j = 0; j < n; j++) begin
                b   = int'($urandom_range(0, 19));
                mag = (b == 0) ? 0 : int'($urandom_range(0, (1 << b) - 1));
                v   = ($urandom_range(0, 1) == 1) ? -mag : mag;
                if ($urandom_range(0, 15) == 0) v = -524288;
                blk.push_back(v);
            end
            run_block((n < int'(BLK_N)) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1, -1, 0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
